// File: rtl/onchip_copy_engine_if.sv
// onchip_copy_engine_if: single-port on-chip memory bus seen by the copy engine.
// The engine drives the master side; the memory (or a model of it) is the slave.
interface onchip_copy_engine_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                clken;
   logic [DATA_W-1:0]   readdata;

   modport master (
      output address, byteenable, chipselect,
      output write, writedata, clken,
      input  readdata
   );

   modport slave (
      input  address, byteenable, chipselect,
      input  write, writedata, clken,
      output readdata
   );
endinterface

// File: rtl/onchip_copy_engine.sv
// onchip_copy_engine: word copier, 3 cycles per word (read, capture, write).
// Define COPY_CHECKSUM_EN to add a running XOR checksum of written words.
module onchip_copy_engine #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_copied,
`ifdef COPY_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   onchip_copy_engine_if.master mem
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   localparam logic [ADDR_W-1:0] INC = 1;
   localparam logic [ADDR_W:0]   ONE = 1;

   state_t            state;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] hold;
   logic              cs_q;
   logic              wr_q;
   logic              kill;

   // An abort during the write cycle must drop the strobe in that same cycle.
   assign kill           = wr_q & abort;
   assign mem.address    = addr_q;
   assign mem.byteenable = '1;
   assign mem.clken      = 1'b1;
   assign mem.chipselect = cs_q & ~kill;
   assign mem.write      = wr_q & ~abort;
   assign mem.writedata  = hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         src          <= '0;
         dst          <= '0;
         addr_q       <= '0;
         remaining    <= '0;
         hold         <= '0;
         cs_q         <= 1'b0;
         wr_q         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         words_copied <= '0;
`ifdef COPY_CHECKSUM_EN
         checksum     <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  words_copied <= '0;
                  busy         <= 1'b1;
`ifdef COPY_CHECKSUM_EN
                  checksum     <= '0;
`endif
                  if (len != '0) begin
                     src       <= src_addr;
                     dst       <= dst_addr;
                     remaining <= len;
                     addr_q    <= src_addr;
                     cs_q      <= 1'b1;
                     wr_q      <= 1'b0;
                     state     <= RD;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RD: begin
               cs_q <= 1'b0;
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= CAP;
               end
            end
            CAP: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hold   <= mem.readdata;
                  addr_q <= dst;
                  cs_q   <= 1'b1;
                  wr_q   <= 1'b1;
                  state  <= WR;
               end
            end
            WR: begin
               cs_q <= 1'b0;
               wr_q <= 1'b0;
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  src          <= src + INC;
                  dst          <= dst + INC;
                  remaining    <= remaining - ONE;
                  words_copied <= words_copied + ONE;
`ifdef COPY_CHECKSUM_EN
                  checksum     <= checksum ^ hold;
`endif
                  if (remaining > ONE) begin
                     addr_q <= src + INC;
                     cs_q   <= 1'b1;
                     state  <= RD;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onchip_copy_engine.sv
// tb_onchip_copy_engine: vector table, hand sequences and random copies
// checked against an array-level copy model with a behavioural memory.
`timescale 1ns/1ps
module tb_onchip_copy_engine;
   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW:0]   len;
      int            abort_wr;
      int            poke;
      int            exp_done;
      int            exp_exit;
      int            exp_wc;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW:0]   words_copied;
`ifdef COPY_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   onchip_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   onchip_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .src_addr(src_addr),
      .dst_addr(dst_addr),
      .len(len),
      .busy(busy),
      .done(done),
      .words_copied(words_copied),
`ifdef COPY_CHECKSUM_EN
      .checksum(checksum),
`endif
      .mem(mem_if)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [4096];
   logic [DW-1:0] ref_mem [4096];
   logic          init_mem;
   logic          poke_we;
   logic [AW-1:0] poke_a;
   logic [DW-1:0] poke_d;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (poke_we) begin
         mem[poke_a] <= poke_d;
      end else if (mem_if.chipselect && mem_if.write && mem_if.clken) begin
         mem[mem_if.address] <= mem_if.writedata;
      end
      if (mem_if.chipselect && !mem_if.write)
         mem_if.readdata <= mem[mem_if.address];
   end

   int nerr = 0;
   int nchk = 0;
   logic [AW-1:0] rd_q[$];
   logic [AW-1:0] wr_q[$];
   vec_t tbl[8];

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model(input vec_t v, output int nrd, output int nwr);
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      nwr = (v.abort_wr != 0) ? v.abort_wr - 1 : int'(v.len);
      nrd = (v.abort_wr != 0) ? v.abort_wr : int'(v.len);
      s = v.src;
      d = v.dst;
      for (int i = 0; i < nwr; i++) begin
         ref_mem[d] = ref_mem[s];
         s = s + 1'b1;
         d = d + 1'b1;
      end
   endtask

   task automatic run_copy(input vec_t v, output int dc, output int xc,
                           output int dn, output logic [AW:0] wc);
      int k;
      bit fin;
      rd_q.delete();
      wr_q.delete();
      @(negedge clk);
      src_addr = v.src;
      dst_addr = v.dst;
      len      = v.len;
      start    = 1'b1;
      k = 0; dc = -1; xc = -1; dn = 0; fin = 0;
      while (!fin) begin
         @(negedge clk);
         k++;
         start = (k == v.poke);
         if (start) begin
            src_addr = '0;
            dst_addr = 12'h800;
            len      = 13'd7;
         end
         abort = (v.abort_wr != 0) && (k == 3 * v.abort_wr);
         #1;
         if (mem_if.chipselect && !mem_if.write) rd_q.push_back(mem_if.address);
         if (mem_if.chipselect && mem_if.write) wr_q.push_back(mem_if.address);
         if (done) begin
            dn++;
            dc = k;
         end
         if (!busy) begin
            xc = k;
            fin = 1;
         end else if (k > 3 * v.len + 8) begin
            xc = -2;
            fin = 1;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      wc = words_copied;
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      int dc, xc, dn, nrd, nwr, bad;
      logic [AW:0]   wc;
      logic [AW-1:0] a;
      model(v, nrd, nwr);
      run_copy(v, dc, xc, dn, wc);
      chk({tag, ".done_cyc"}, dc, v.exp_done);
      chk({tag, ".done_cnt"}, dn, (v.exp_done >= 0) ? 1 : 0);
      chk({tag, ".exit_cyc"}, xc, v.exp_exit);
      chk({tag, ".words_copied"}, wc, v.exp_wc);
      chk({tag, ".n_reads"}, rd_q.size(), nrd);
      chk({tag, ".n_writes"}, wr_q.size(), nwr);
      bad = 0;
      a = v.src;
      foreach (rd_q[i]) begin
         if (rd_q[i] !== a) bad++;
         a = a + 1'b1;
      end
      chk({tag, ".rd_addr_bad"}, bad, 0);
      bad = 0;
      a = v.dst;
      foreach (wr_q[i]) begin
         if (wr_q[i] !== a) bad++;
         a = a + 1'b1;
      end
      chk({tag, ".wr_addr_bad"}, bad, 0);
      bad = 0;
      foreach (mem[i]) if (mem[i] !== ref_mem[i]) bad++;
      chk({tag, ".mem_bad"}, bad, 0);
   endtask

   initial begin
      vec_t v;
      int   seen;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; len = '0;
      poke_we = 1'b0; poke_a = '0; poke_d = '0;
      init_mem = 1'b1;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
      repeat (3) @(negedge clk);
      init_mem = 1'b0;
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.words_copied", words_copied, 0);
      chk("rst.chipselect", mem_if.chipselect, 0);
      chk("rst.write", mem_if.write, 0);
      chk("rst.byteenable", mem_if.byteenable, 4'hF);
      chk("rst.clken", mem_if.clken, 1);
      @(negedge clk);
      reset = 1'b0;

      tbl[0] = '{12'h010, 12'h100, 13'd4,  0, 0, 13, 14, 4};
      tbl[1] = '{12'h123, 12'h456, 13'd0,  0, 0,  1,  2, 0};
      tbl[2] = '{12'hFFE, 12'h020, 13'd3,  0, 0, 10, 11, 3};
      tbl[3] = '{12'h200, 12'h300, 13'd10, 2, 0, -1,  7, 1};
      tbl[4] = '{12'h050, 12'h052, 13'd5,  0, 4, 16, 17, 5};
      tbl[5] = '{12'h7FF, 12'hFFF, 13'd2,  0, 0,  7,  8, 2};
      tbl[6] = '{12'h400, 12'h401, 13'd1,  0, 0,  4,  5, 1};
      tbl[7] = '{12'h500, 12'h600, 13'd3,  1, 0, -1,  4, 0};
      for (int i = 0; i < 8; i++) begin
         check_vec(tbl[i], $sformatf("vec%0d", i));
         if (i == 0) begin
            chk("vec0.mem100", mem[12'h100], 32'hA500_0010);
            chk("vec0.mem103", mem[12'h103], 32'hA500_0013);
         end
      end

      @(negedge clk);
      src_addr = 12'h030; dst_addr = 12'h900; len = 13'd3;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      seen = 0;
      repeat (4) begin
         #1;
         if (busy || done || mem_if.chipselect) seen++;
         @(negedge clk);
      end
      chk("abort_start_idle", seen, 0);

      @(negedge clk);
      src_addr = 12'h010; dst_addr = 12'h700; len = 13'd5; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.words_copied", words_copied, 0);
      chk("midrst.address", mem_if.address, 0);
      chk("midrst.chipselect", mem_if.chipselect, 0);
      chk("midrst.write", mem_if.write, 0);
      chk("midrst.writedata", mem_if.writedata, 0);
      chk("midrst.byteenable", mem_if.byteenable, 4'hF);
      chk("midrst.clken", mem_if.clken, 1);
      ref_mem[12'h700] = ref_mem[12'h010];
      v = '{12'h600, 12'h610, 13'd1, 0, 0, 4, 5, 1};
      check_vec(v, "after_rst");

`ifdef COPY_CHECKSUM_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         poke_we = 1'b1;
         poke_a  = 12'h300 + 12'(i);
         poke_d  = 32'(1 << i);
         ref_mem[12'h300 + 12'(i)] = 32'(1 << i);
      end
      @(negedge clk);
      poke_we = 1'b0;
      v = '{12'h300, 12'h310, 13'd3, 0, 0, 10, 11, 3};
      check_vec(v, "csum_vec");
      chk("checksum", checksum, 7);
`endif

      for (int r = 0; r < 20; r++) begin
         v.src = 12'($urandom);
         v.dst = 12'($urandom);
         v.len = 13'($urandom_range(1, 8));
         v.abort_wr = ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(1, int'(v.len))) : 0;
         v.poke = 0;
         if (v.abort_wr != 0) begin
            v.exp_done = -1;
            v.exp_exit = 3 * v.abort_wr + 1;
            v.exp_wc   = v.abort_wr - 1;
         end else begin
            v.exp_done = 3 * int'(v.len) + 1;
            v.exp_exit = 3 * int'(v.len) + 2;
            v.exp_wc   = int'(v.len);
         end
         check_vec(v, $sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/onchip_copy_engine.md
ONCHIP_COPY_ENGINE -- requirements
Module: onchip_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the attached on-chip memory (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; byte lanes = DATA_W/8.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 abort  input  1  terminate an active copy.
REQ-007 src_addr  input  ADDR_W  first source word address, captured on accepted start.
REQ-008 dst_addr  input  ADDR_W  first destination word address, captured on accepted start.
REQ-009 len  input  ADDR_W+1  word count 0..4096, captured on accepted start.
REQ-010 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 words_copied  output  ADDR_W+1  count of destination writes issued in current/last copy.
REQ-013 address  output  ADDR_W  memory word address.
REQ-014 byteenable  output  DATA_W/8  memory byte enables, constant all-ones.
REQ-015 chipselect  output  1  memory select.
REQ-016 write  output  1  memory write strobe, only asserted with chipselect.
REQ-017 writedata  output  DATA_W  memory write data.
REQ-018 clken  output  1  memory clock enable, constant 1.
REQ-019 readdata  input  DATA_W  memory read data, valid exactly one cycle after a read cycle (chipselect=1, write=0).

Function
REQ-020 SHALL implement states IDLE, RD, CAP, WR, DONE.
REQ-021 IDLE: start=1 with len>0 -> capture src/dst/len, clear words_copied, go RD; start=1 with len=0 -> go DONE, no memory access.
REQ-022 RD: chipselect=1, write=0, address=current src; next state CAP.
REQ-023 CAP: chipselect=0; latch readdata into a DATA_W holding register; next state WR.
REQ-024 WR: chipselect=1, write=1, address=current dst, writedata=holding register; increment src, dst, words_copied; decrement remaining; next RD if remaining>1 else DONE.
REQ-025 Each word SHALL take exactly 3 cycles; a copy of N>0 words SHALL reach DONE 3N+1 cycles after the start cycle.
REQ-026 DONE: done=1 for exactly one cycle, busy=0 thereafter, next state IDLE.
REQ-027 src and dst SHALL increment modulo 2^ADDR_W (wrap 4095 -> 0).
REQ-028 Copy order SHALL be ascending; overlapping ranges with dst>src propagate already-copied words (defined, not an error).
REQ-029 start while not in IDLE SHALL be ignored.
REQ-030 abort in RD, CAP or WR SHALL force IDLE next cycle; abort in WR suppresses that write (write=0 that cycle); no done pulse; words_copied holds.
REQ-031 abort and start together in IDLE: abort wins, start ignored.
REQ-032 In IDLE and DONE: chipselect=0, write=0.

Reset
REQ-033 reset SHALL take priority over all inputs, including mid-copy, and return to IDLE on the next edge.
REQ-034 Reset values: busy=0, done=0, words_copied=0, address=0, chipselect=0, write=0, writedata=0, holding register=0; byteenable=all-ones, clken=1.

Configuration
REQ-035 Macro COPY_CHECKSUM_EN SHALL, when defined, add output checksum [DATA_W-1:0]: cleared on accepted start and on reset, XORed with each word written in WR, stable from DONE until next accepted start.
REQ-036 Without COPY_CHECKSUM_EN the checksum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 Memory preloaded mem[i]=0xA5000000+i; start src=0x010 dst=0x100 len=4 -> mem[0x100..0x103]=0xA5000010..0xA5000013, done 13 cycles after start, words_copied=4.
REQ-038 start len=0 -> done next cycle after start, chipselect never asserted, words_copied=0.
REQ-039 start src=0xFFE dst=0x020 len=3 -> reads 0xFFE, 0xFFF, 0x000; writes 0x020..0x022.
REQ-040 start len=10, abort asserted in 2nd WR cycle -> exactly 1 write issued, IDLE next cycle, no done, words_copied=1.
REQ-041 reset asserted in CAP of a len=5 copy -> next cycle all outputs at reset values; subsequent start len=1 completes normally.
REQ-042 COPY_CHECKSUM_EN defined, copy words 0x1, 0x2, 0x4 -> checksum=0x7 at done.
